// File: rtl/usb_link_ctrl_pkg.sv
// rtl/usb_link_ctrl_pkg.sv - shared types and 24 MHz cycle defaults for the USB link controller
package usb_link_ctrl_pkg;

    typedef enum logic [1:0] {
        SE0 = 2'b00,
        J   = 2'b01,
        K   = 2'b10,
        SE1 = 2'b11
    } d_port_t;

    typedef enum logic [2:0] {
        ACTIVE    = 3'd0,
        BUS_RESET = 3'd1,
        SUSPENDED = 3'd2,
        RESUMING  = 3'd3,
        WAKEUP    = 3'd4
    } link_state_t;

    localparam int unsigned SE0_CNT_W  = 8;
    localparam int unsigned IDLE_CNT_W = 17;

    localparam int unsigned RESET_CYCLES_DEF      = 60;
    localparam int unsigned SUSPEND_CYCLES_DEF    = 72000;
    localparam int unsigned WAKE_WAIT_CYCLES_DEF  = 120000;
    localparam int unsigned WAKE_DRIVE_CYCLES_DEF = 48000;

endpackage

// File: rtl/usb_run_counter.sv
// rtl/usb_run_counter.sv - saturating run-length counter with increment and clear
module usb_run_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != {WIDTH{1'b1}})) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/usb_link_ctrl.sv
// rtl/usb_link_ctrl.sv - full-speed device bus-state controller: reset, suspend, resume, remote wakeup
module usb_link_ctrl
    import usb_link_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES      = RESET_CYCLES_DEF,
    parameter int unsigned SUSPEND_CYCLES    = SUSPEND_CYCLES_DEF,
    parameter int unsigned WAKE_WAIT_CYCLES  = WAKE_WAIT_CYCLES_DEF,
    parameter int unsigned WAKE_DRIVE_CYCLES = WAKE_DRIVE_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_i,
    input  d_port_t     line_state,
    input  logic        remote_wake_en,
    input  logic        wake_req,
    output logic        usb_reset_o,
    output logic        suspend_o,
    output logic        resume_o,
    output logic        drive_k_o,
    output link_state_t state_o
);

    localparam logic [SE0_CNT_W-1:0]  RESET_LAST   = SE0_CNT_W'(RESET_CYCLES - 1);
    localparam logic [IDLE_CNT_W-1:0] SUSPEND_LAST = IDLE_CNT_W'(SUSPEND_CYCLES - 1);
    localparam logic [IDLE_CNT_W-1:0] WAIT_LAST    = IDLE_CNT_W'(WAKE_WAIT_CYCLES - 1);
    localparam logic [IDLE_CNT_W-1:0] DRIVE_LAST   = IDLE_CNT_W'(WAKE_DRIVE_CYCLES - 1);

    link_state_t state_q, state_d;
    logic        wake_pending_q, wake_pending_d;
    logic        suspend_q, suspend_d;
    logic        resume_q, resume_d;
    logic        drive_k_q, drive_k_d;

    logic [SE0_CNT_W-1:0]  se0_cnt;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic                  se0_inc, se0_clr;
    logic                  idle_inc, idle_clr;
    logic                  reset_hit;
    logic                  wake_go;

    // Our own K drive must not be mistaken for line activity, so SE0 counting is frozen in WAKEUP.
    assign se0_inc   = (line_state == SE0) && (state_q != WAKEUP);
    assign se0_clr   = !se0_inc;
    assign reset_hit = (se0_cnt == RESET_LAST) && (line_state == SE0);
    assign wake_go   = (wake_pending_q || wake_req) && remote_wake_en && (idle_cnt >= WAIT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACTIVE: begin
                if (reset_hit) begin
                    state_d = BUS_RESET;
                end else if ((line_state == J) && (idle_cnt == SUSPEND_LAST)) begin
                    state_d = SUSPENDED;
                end
            end
            BUS_RESET: begin
                if (line_state != SE0) state_d = ACTIVE;
            end
            SUSPENDED: begin
                if (reset_hit) begin
                    state_d = BUS_RESET;
                end else if (line_state == K) begin
                    state_d = RESUMING;
                end else if (wake_go) begin
                    state_d = WAKEUP;
                end
            end
            WAKEUP: begin
                if (idle_cnt == DRIVE_LAST) state_d = RESUMING;
            end
            RESUMING: begin
                if ((line_state == SE0) || (line_state == J)) state_d = ACTIVE;
            end
            default: state_d = ACTIVE;
        endcase
    end

    always_comb begin
        idle_inc = 1'b0;
        case (state_q)
            ACTIVE:    idle_inc = (line_state == J);
            SUSPENDED: idle_inc = 1'b1;
            WAKEUP:    idle_inc = 1'b1;
            default:   idle_inc = 1'b0;
        endcase
        idle_clr = (state_d != state_q) || !idle_inc;
    end

    always_comb begin
        wake_pending_d = 1'b0;
        if ((state_q == SUSPENDED) && (state_d == SUSPENDED)) begin
            wake_pending_d = wake_pending_q || (wake_req && remote_wake_en);
        end
        suspend_d = (state_d == SUSPENDED);
        drive_k_d = (state_d == WAKEUP);
        resume_d  = (state_q == RESUMING) && (state_d == ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q        <= ACTIVE;
            wake_pending_q <= 1'b0;
            suspend_q      <= 1'b0;
            resume_q       <= 1'b0;
            drive_k_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wake_pending_q <= wake_pending_d;
            suspend_q      <= suspend_d;
            resume_q       <= resume_d;
            drive_k_q      <= drive_k_d;
        end
    end

    usb_run_counter #(.WIDTH(SE0_CNT_W)) u_se0_cnt (
        .clk     (clk),
        .reset_i (reset_i),
        .inc     (se0_inc),
        .clr     (se0_clr),
        .value   (se0_cnt)
    );

    usb_run_counter #(.WIDTH(IDLE_CNT_W)) u_idle_cnt (
        .clk     (clk),
        .reset_i (reset_i),
        .inc     (idle_inc),
        .clr     (idle_clr),
        .value   (idle_cnt)
    );

    assign usb_reset_o = reset_i || (state_q == BUS_RESET);
    assign suspend_o   = suspend_q;
    assign resume_o    = resume_q;
    assign drive_k_o   = drive_k_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_usb_link_ctrl.sv
// tb/tb_usb_link_ctrl.sv - directed-vector bench for usb_link_ctrl with scaled-down cycle parameters
module tb_usb_link_ctrl;
    import usb_link_ctrl_pkg::*;

    localparam int unsigned T_RESET = 60;
    localparam int unsigned T_SUSP  = 720;
    localparam int unsigned T_WAIT  = 1200;
    localparam int unsigned T_DRIVE = 480;

    logic        clk;
    logic        reset_i;
    d_port_t     line_state;
    logic        remote_wake_en;
    logic        wake_req;
    logic        usb_reset_o;
    logic        suspend_o;
    logic        resume_o;
    logic        drive_k_o;
    link_state_t state_o;

    int n_vec;
    int n_err;

    usb_link_ctrl #(
        .RESET_CYCLES      (T_RESET),
        .SUSPEND_CYCLES    (T_SUSP),
        .WAKE_WAIT_CYCLES  (T_WAIT),
        .WAKE_DRIVE_CYCLES (T_DRIVE)
    ) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .line_state     (line_state),
        .remote_wake_en (remote_wake_en),
        .wake_req       (wake_req),
        .usb_reset_o    (usb_reset_o),
        .suspend_o      (suspend_o),
        .resume_o       (resume_o),
        .drive_k_o      (drive_k_o),
        .state_o        (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input link_state_t exp);
        chk(tag, int'(state_o), int'(exp));
    endtask

    task automatic go_suspended;
        line_state = K;
        tick(1);
        line_state = J;
        tick(T_SUSP);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_i = 1'b1;
        line_state = J;
        remote_wake_en = 1'b0;
        wake_req = 1'b0;

        // reset behaviour
        tick(3);
        chk("rst_usb_reset", int'(usb_reset_o), 1);
        chk_state("rst_state", ACTIVE);
        chk("rst_suspend", int'(suspend_o), 0);
        chk("rst_resume", int'(resume_o), 0);
        chk("rst_drive_k", int'(drive_k_o), 0);
        reset_i = 1'b0;
        tick(1);
        chk("rel_usb_reset", int'(usb_reset_o), 0);

        // bus reset qualification boundary
        line_state = SE0;
        tick(T_RESET - 1);
        line_state = J;
        tick(1);
        chk_state("se0_59_no_reset", ACTIVE);
        line_state = SE0;
        tick(T_RESET - 1);
        chk_state("se0_59_active", ACTIVE);
        tick(1);
        chk_state("se0_60_bus_reset", BUS_RESET);
        chk("se0_60_usb_reset", int'(usb_reset_o), 1);
        tick(100);
        chk_state("bus_reset_hold", BUS_RESET);
        line_state = J;
        tick(1);
        chk_state("bus_reset_exit", ACTIVE);
        chk("bus_reset_exit_usb_reset", int'(usb_reset_o), 0);

        // SE1 breaks an SE0 run
        line_state = SE0;
        tick(30);
        line_state = SE1;
        tick(1);
        line_state = SE0;
        tick(T_RESET - 1);
        chk_state("se1_clears_se0", ACTIVE);
        tick(1);
        chk_state("se1_then_se0_60", BUS_RESET);
        line_state = J;
        tick(1);

        // suspend boundary and host resume
        line_state = K;
        tick(1);
        line_state = J;
        tick(T_SUSP - 1);
        line_state = K;
        tick(1);
        chk("susp_719_no", int'(suspend_o), 0);
        chk_state("susp_719_state", ACTIVE);
        line_state = J;
        tick(T_SUSP - 1);
        chk("susp_pre", int'(suspend_o), 0);
        tick(1);
        chk("susp_720", int'(suspend_o), 1);
        chk_state("susp_720_state", SUSPENDED);
        line_state = K;
        tick(1);
        chk_state("host_k_resuming", RESUMING);
        chk("host_k_suspend", int'(suspend_o), 0);
        line_state = SE0;
        tick(1);
        chk_state("eop_active", ACTIVE);
        chk("eop_resume_pulse", int'(resume_o), 1);
        tick(1);
        chk("eop_resume_drop", int'(resume_o), 0);
        line_state = J;
        tick(1);
        chk_state("eop_no_bus_reset", ACTIVE);

        // remote wakeup with early request
        go_suspended();
        chk_state("rw_suspended", SUSPENDED);
        remote_wake_en = 1'b1;
        tick(99);
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        chk_state("rw_req_held", SUSPENDED);
        tick(T_WAIT - 101);
        chk_state("rw_before_wait", SUSPENDED);
        tick(1);
        chk_state("rw_wakeup", WAKEUP);
        chk("rw_drive_k_on", int'(drive_k_o), 1);
        line_state = SE0;
        tick(T_DRIVE - 1);
        chk_state("rw_drive_last", WAKEUP);
        chk("rw_drive_k_last", int'(drive_k_o), 1);
        line_state = K;
        tick(1);
        chk_state("rw_resuming", RESUMING);
        chk("rw_drive_k_off", int'(drive_k_o), 0);
        tick(5);
        chk_state("rw_host_k_hold", RESUMING);
        line_state = J;
        tick(1);
        chk_state("rw_active", ACTIVE);
        chk("rw_resume_pulse", int'(resume_o), 1);
        tick(1);
        chk("rw_resume_drop", int'(resume_o), 0);

        // wakeup disabled, then bus reset from suspend
        remote_wake_en = 1'b0;
        go_suspended();
        tick(1999);
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        tick(10);
        chk_state("nw_still_suspended", SUSPENDED);
        chk("nw_drive_k", int'(drive_k_o), 0);
        line_state = SE0;
        tick(T_RESET);
        chk_state("nw_bus_reset", BUS_RESET);
        chk("nw_suspend_off", int'(suspend_o), 0);
        chk("nw_usb_reset", int'(usb_reset_o), 1);
        line_state = J;
        tick(1);

        // reset_i mid-drive
        remote_wake_en = 1'b1;
        go_suspended();
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        tick(T_WAIT - 1);
        chk_state("mr_wakeup", WAKEUP);
        tick(100);
        chk("mr_drive_k_pre", int'(drive_k_o), 1);
        reset_i = 1'b1;
        tick(1);
        chk("mr_drive_k_off", int'(drive_k_o), 0);
        chk_state("mr_state", ACTIVE);
        chk("mr_resume", int'(resume_o), 0);
        chk("mr_usb_reset", int'(usb_reset_o), 1);
        reset_i = 1'b0;
        tick(1);
        chk("mr_resume_after", int'(resume_o), 0);
        chk("mr_usb_reset_after", int'(usb_reset_o), 0);
        go_suspended();
        tick(T_WAIT + 100);
        chk_state("mr_pending_cleared", SUSPENDED);
        chk("mr_no_drive", int'(drive_k_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
